// File: rtl/uart_bridge_pkg.sv
// Shared constants and state types for the UART-to-bus bridge.
// Contents: command opcodes, response bytes, top and receiver FSM state
// encodings, and the payload-to-bus transition target.
// Build option: UART_BRIDGE_CSUM_EN adds the S_CSUM state, a trailing
// request checksum byte and a checksum byte after every response.
package uart_bridge_pkg;

  localparam logic [7:0] OP_WRITE = 8'h57;  // 'W'
  localparam logic [7:0] OP_READ  = 8'h52;  // 'R'
  localparam logic [7:0] RSP_ACK  = 8'h4B;  // 'K'
  localparam logic [7:0] RSP_ERR  = 8'h45;  // 'E'

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_DATA = 3'd2,
`ifdef UART_BRIDGE_CSUM_EN
    S_CSUM = 3'd3,
`endif
    S_BUS  = 3'd4,
    S_RESP = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    R_HUNT  = 2'd0,
    R_START = 2'd1,
    R_DATA  = 2'd2,
    R_STOP  = 2'd3
  } rx_state_t;

`ifdef UART_BRIDGE_CSUM_EN
  // After the payload the frame still owes its checksum byte.
  localparam state_t     S_AFTER_PAYLOAD = S_CSUM;
  // Number of response bytes added after the payload (the checksum).
  localparam logic [2:0] RSP_TAIL        = 3'd1;
`else
  localparam state_t     S_AFTER_PAYLOAD = S_BUS;
  localparam logic [2:0] RSP_TAIL        = 3'd0;
`endif

endpackage

// File: rtl/uart_byte_rx.sv
// UART 8N1 byte receiver.
// Ports: clk/rst (async active-high), rx_i (raw asynchronous line, idle high),
//   rx_valid_o (one-clock pulse per good byte), rx_byte_o (received byte,
//   stable from rx_valid_o until the next byte), rx_ferr_o (one-clock pulse
//   when the stop bit samples low), rx_state_o (receiver FSM state).
module uart_byte_rx
  import uart_bridge_pkg::*;
#(
  parameter logic [15:0] BAUD_DIV = 16'd434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic       rx_valid_o,
  output logic [7:0] rx_byte_o,
  output logic       rx_ferr_o,
  output rx_state_t  rx_state_o
);

  localparam logic [15:0] HALF = BAUD_DIV >> 1;

  logic        sync1_q, sync2_q, prev_q;
  rx_state_t   st_q, st_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  sh_q, sh_d;
  logic        valid_q, valid_d, ferr_q, ferr_d;

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q + 16'd1;
    bit_d   = bit_q;
    sh_d    = sh_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (st_q)
      R_HUNT: begin
        cnt_d = '0;
        if (prev_q && !sync2_q) st_d = R_START;
      end
      R_START: begin
        // Mid start bit: a high line here means the falling edge was a glitch.
        if (cnt_q == HALF - 16'd1) begin
          cnt_d = '0;
          bit_d = 3'd0;
          st_d  = sync2_q ? R_HUNT : R_DATA;
        end
      end
      R_DATA: begin
        if (cnt_q == BAUD_DIV - 16'd1) begin
          cnt_d = '0;
          sh_d  = {sync2_q, sh_q[7:1]};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) st_d = R_STOP;
        end
      end
      R_STOP: begin
        if (cnt_q == BAUD_DIV - 16'd1) begin
          st_d    = R_HUNT;
          valid_d = sync2_q;
          ferr_d  = !sync2_q;
        end
      end
      default: st_d = R_HUNT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      st_q    <= R_HUNT;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign rx_valid_o = valid_q;
  assign rx_ferr_o  = ferr_q;
  assign rx_byte_o  = sh_q;
  assign rx_state_o = st_q;

endmodule

// File: rtl/uart_bus_bridge.sv
// UART-to-bus initiator: receives W/R command frames over 8N1 UART, issues
// one 32-bit bus cycle and answers with 'K', read data, or 'E'.
// Ports: clk/rst (async active-high); rx_pin/tx_pin UART lines (idle high);
//   mem_req_o one-clock bus request, mem_we_o write strobe, mem_addr_o and
//   mem_data_o held bus address/write data, mem_data_i read data sampled in
//   the request cycle; busy_o high outside S_IDLE; err_o one-clock error
//   pulse; dbg_state_o / dbg_rx_state_o expose the two FSM states.
// Handshake: the bus has no stall; mem_req_o is a single-clock strobe and
//   mem_data_i must be valid combinationally in that same clock.
// Build option: UART_BRIDGE_CSUM_EN enables request/response checksums.
module uart_bus_bridge
  import uart_bridge_pkg::*;
#(
  parameter logic [15:0] BAUD_DIV    = 16'd434,
  parameter logic [31:0] TIMEOUT_CYC = 32'd500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_pin,
  output logic        tx_pin,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  input  logic [31:0] mem_data_i,
  output logic        busy_o,
  output logic        err_o,
  output state_t      dbg_state_o,
  output rx_state_t   dbg_rx_state_o
);

  logic       rx_valid, rx_ferr;
  logic [7:0] rx_byte;

  uart_byte_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rx_i      (rx_pin),
    .rx_valid_o(rx_valid),
    .rx_byte_o (rx_byte),
    .rx_ferr_o (rx_ferr),
    .rx_state_o(dbg_rx_state_o)
  );

  state_t      state_q, state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic        is_wr_q, is_wr_d;
  logic [31:0] addr_sh_q, addr_sh_d, data_sh_q, data_sh_d;
  logic [31:0] timer_q, timer_d;
  logic [31:0] mem_addr_q, mem_addr_d, mem_data_q, mem_data_d;
  logic [39:0] resp_buf_q, resp_buf_d;
  logic [2:0]  resp_last_q, resp_last_d, resp_idx_q, resp_idx_d;
  logic        err_q, err_d;
  logic [7:0]  rd_csum;

  // TX shifter
  logic        tx_active_q, tx_load, tx_done;
  logic [9:0]  tx_frame_q;
  logic [15:0] tx_cnt_q;
  logic [3:0]  tx_nbit_q;
  logic [7:0]  tx_load_byte;

`ifdef UART_BRIDGE_CSUM_EN
  logic [7:0] csum_q;
  // Running XOR of the request frame, restarted by the opcode byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           csum_q <= '0;
    else if (rx_valid) csum_q <= (state_q == S_IDLE) ? rx_byte : (csum_q ^ rx_byte);
  end
  assign rd_csum = mem_data_i[7:0] ^ mem_data_i[15:8] ^ mem_data_i[23:16] ^ mem_data_i[31:24];
`else
  assign rd_csum = 8'h00;
`endif

  assign tx_done = tx_active_q && (tx_cnt_q == BAUD_DIV - 16'd1) && (tx_nbit_q == 4'd9);
  assign tx_load_byte = resp_buf_q[{resp_idx_d, 3'b000} +: 8];

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    is_wr_d     = is_wr_q;
    addr_sh_d   = addr_sh_q;
    data_sh_d   = data_sh_q;
    timer_d     = '0;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    resp_buf_d  = resp_buf_q;
    resp_last_d = resp_last_q;
    resp_idx_d  = resp_idx_q;
    err_d       = 1'b0;
    tx_load     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        byte_cnt_d = 2'd0;
        if (rx_valid) begin
          if (rx_byte == OP_WRITE || rx_byte == OP_READ) begin
            is_wr_d = (rx_byte == OP_WRITE);
            state_d = S_ADDR;
          end else begin
            err_d       = 1'b1;
            resp_buf_d  = {24'h0, RSP_ERR, RSP_ERR};
            resp_last_d = RSP_TAIL;
            resp_idx_d  = 3'd0;
            state_d     = S_RESP;
          end
        end
      end
      S_ADDR: begin
        timer_d = timer_q + 32'd1;
        if (rx_valid) begin
          timer_d = '0;
          addr_sh_d[{byte_cnt_q, 3'b000} +: 8] = rx_byte;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) state_d = is_wr_q ? S_DATA : S_AFTER_PAYLOAD;
        end else if (timer_q == TIMEOUT_CYC - 32'd1) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DATA: begin
        timer_d = timer_q + 32'd1;
        if (rx_valid) begin
          timer_d = '0;
          data_sh_d[{byte_cnt_q, 3'b000} +: 8] = rx_byte;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) state_d = S_AFTER_PAYLOAD;
        end else if (timer_q == TIMEOUT_CYC - 32'd1) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
`ifdef UART_BRIDGE_CSUM_EN
      S_CSUM: begin
        timer_d = timer_q + 32'd1;
        if (rx_valid) begin
          if (rx_byte == csum_q) begin
            state_d = S_BUS;
          end else begin
            err_d       = 1'b1;
            resp_buf_d  = {24'h0, RSP_ERR, RSP_ERR};
            resp_last_d = RSP_TAIL;
            resp_idx_d  = 3'd0;
            state_d     = S_RESP;
          end
        end else if (timer_q == TIMEOUT_CYC - 32'd1) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
`endif
      S_BUS: begin
        if (is_wr_q) begin
          resp_buf_d  = {24'h0, RSP_ACK, RSP_ACK};
          resp_last_d = RSP_TAIL;
        end else begin
          resp_buf_d  = {rd_csum, mem_data_i};
          resp_last_d = 3'd3 + RSP_TAIL;
        end
        resp_idx_d = 3'd0;
        state_d    = S_RESP;
      end
      S_RESP: begin
        // The next byte is loaded in the cycle the previous stop bit ends,
        // so consecutive response bytes leave no idle gap.
        if (!tx_active_q) begin
          tx_load = 1'b1;
        end else if (tx_done) begin
          if (resp_idx_q == resp_last_q) begin
            state_d = S_IDLE;
          end else begin
            resp_idx_d = resp_idx_q + 3'd1;
            tx_load    = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A framing error drops any frame being received; during S_BUS/S_RESP
    // the host is waiting for the response, so the transaction continues.
    if (rx_ferr) begin
      err_d = 1'b1;
      if (state_q != S_BUS && state_q != S_RESP) state_d = S_IDLE;
    end

    // Bus address/data are latched on entry to S_BUS so they are valid in
    // the request cycle and held until the next frame reaches S_BUS.
    if (state_d == S_BUS) begin
      mem_addr_d = addr_sh_d;
      if (is_wr_q) mem_data_d = data_sh_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      byte_cnt_q  <= '0;
      is_wr_q     <= 1'b0;
      addr_sh_q   <= '0;
      data_sh_q   <= '0;
      timer_q     <= '0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      resp_buf_q  <= '0;
      resp_last_q <= '0;
      resp_idx_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      is_wr_q     <= is_wr_d;
      addr_sh_q   <= addr_sh_d;
      data_sh_q   <= data_sh_d;
      timer_q     <= timer_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      resp_buf_q  <= resp_buf_d;
      resp_last_q <= resp_last_d;
      resp_idx_q  <= resp_idx_d;
      err_q       <= err_d;
    end
  end

  // Frame is {stop, data[7:0], start}, shifted out LSB first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_active_q <= 1'b0;
      tx_frame_q  <= '1;
      tx_cnt_q    <= '0;
      tx_nbit_q   <= '0;
    end else if (tx_load) begin
      tx_active_q <= 1'b1;
      tx_frame_q  <= {1'b1, tx_load_byte, 1'b0};
      tx_cnt_q    <= '0;
      tx_nbit_q   <= '0;
    end else if (tx_active_q) begin
      if (tx_cnt_q == BAUD_DIV - 16'd1) begin
        tx_cnt_q <= '0;
        if (tx_nbit_q == 4'd9) begin
          tx_active_q <= 1'b0;
        end else begin
          tx_nbit_q  <= tx_nbit_q + 4'd1;
          tx_frame_q <= {1'b1, tx_frame_q[9:1]};
        end
      end else begin
        tx_cnt_q <= tx_cnt_q + 16'd1;
      end
    end
  end

  assign tx_pin      = tx_active_q ? tx_frame_q[0] : 1'b1;
  assign mem_req_o   = (state_q == S_BUS);
  assign mem_we_o    = (state_q == S_BUS) && is_wr_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_data_o  = mem_data_q;
  assign busy_o      = (state_q != S_IDLE);
  assign err_o       = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Bench for uart_bus_bridge: directed frames, a frame-level reference model
// producing expected bus cycles, response bytes and error pulses, and
// monitors that decode the bus and tx line and compare on every event.
module tb_uart_bus_bridge;
  import uart_bridge_pkg::*;

  localparam int BIT = 16;
`ifdef UART_BRIDGE_CSUM_EN
  localparam int RSP_X = 1;
`else
  localparam int RSP_X = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_pin;
  logic        tx_pin;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_data_o, mem_data_i;
  logic        busy_o, err_o;
  state_t      dbg_state;
  rx_state_t   dbg_rx_state;
  logic [31:0] rd_data;

  always #5 clk = ~clk;

  uart_bus_bridge #(.BAUD_DIV(16'd16), .TIMEOUT_CYC(32'd2000)) dut (
    .clk(clk), .rst(rst), .rx_pin(rx_pin), .tx_pin(tx_pin),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .busy_o(busy_o),
    .err_o(err_o), .dbg_state_o(dbg_state), .dbg_rx_state_o(dbg_rx_state)
  );

  // Responder drives read data only in a read request cycle.
  assign mem_data_i = (mem_req_o && !mem_we_o) ? rd_data : 32'h0;

  int tests_run = 0;
  int tests_failed = 0;
  int err_seen = 0;
  int exp_err = 0;
  int rst_epoch = 0;
  int cyc = 0;

  logic [7:0]  exp_q[$];
  logic [64:0] exp_bus_q[$];   // {we, addr, data}
  logic [7:0]  frame_q[$];
  int          tx_starts_q[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Bus and error monitor.
  always @(negedge clk) begin
    if (!rst) begin
      if (err_o) err_seen++;
      if (mem_we_o) chk("we_only_with_req", {63'd0, mem_req_o}, 64'd1);
      if (mem_req_o) begin
        if (exp_bus_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL bus_unexpected: got req addr %0h expected no bus cycle", mem_addr_o);
        end else begin
          logic [64:0] e;
          e = exp_bus_q.pop_front();
          chk("bus_we", {63'd0, mem_we_o}, {63'd0, e[64]});
          chk("bus_addr", {32'd0, mem_addr_o}, {32'd0, e[63:32]});
          if (e[64]) chk("bus_wdata", {32'd0, mem_data_o}, {32'd0, e[31:0]});
        end
      end
    end
  end

  // TX line decoder; bytes interrupted by a reset are discarded.
  initial begin : tx_mon
    logic [7:0] b;
    logic       sb, pb;
    int         ep, st;
    forever begin
      @(negedge clk);
      if (!rst && tx_pin === 1'b0) begin
        ep = rst_epoch;
        st = cyc;
        repeat (8) @(negedge clk);
        sb = tx_pin;
        for (int i = 0; i < 8; i++) begin
          repeat (BIT) @(negedge clk);
          b[i] = tx_pin;
        end
        repeat (BIT) @(negedge clk);
        pb = tx_pin;
        if (ep == rst_epoch) begin
          tx_starts_q.push_back(st);
          if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL tx_unexpected: got byte %0h expected no tx", b);
          end else begin
            chk("tx_byte", {56'd0, b}, {56'd0, exp_q.pop_front()});
            chk("tx_start_stop", {62'd0, sb, pb}, 64'd1);
          end
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_v);
    rx_pin = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_pin = b[i];
      repeat (BIT) @(negedge clk);
    end
    rx_pin = stop_v;
    repeat (BIT) @(negedge clk);
    rx_pin = 1'b1;
  endtask

  task automatic send_frame();
    for (int i = 0; i < frame_q.size(); i++) begin
      send_byte(frame_q[i], 1'b1);
      repeat (i % 3) @(negedge clk);
    end
  endtask

  task automatic build(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d);
    logic [7:0] x;
    frame_q.delete();
    frame_q.push_back(op);
    for (int i = 0; i < 4; i++) frame_q.push_back(a[8*i +: 8]);
    if (op == 8'h57) for (int i = 0; i < 4; i++) frame_q.push_back(d[8*i +: 8]);
`ifdef UART_BRIDGE_CSUM_EN
    x = 8'h00;
    foreach (frame_q[i]) x = x ^ frame_q[i];
    frame_q.push_back(x);
`else
    x = 8'h00;
    if (x != 8'h00) frame_q.push_back(x);
`endif
  endtask

  // Frame-level reference: what the host must observe for frame_q.
  task automatic model_frame();
    logic [7:0]  op, x;
    logic [31:0] a, d;
    int          n;
    op = frame_q[0];
    if (op != 8'h57 && op != 8'h52) begin
      exp_err++;
      exp_q.push_back(8'h45);
      if (RSP_X == 1) exp_q.push_back(8'h45);
      return;
    end
    a = {frame_q[4], frame_q[3], frame_q[2], frame_q[1]};
    n = 5;
    d = rd_data;
    if (op == 8'h57) begin
      d = {frame_q[8], frame_q[7], frame_q[6], frame_q[5]};
      n = 9;
    end
    if (RSP_X == 1) begin
      x = 8'h00;
      for (int i = 0; i < n; i++) x = x ^ frame_q[i];
      if (x != frame_q[n]) begin
        exp_err++;
        exp_q.push_back(8'h45);
        exp_q.push_back(8'h45);
        return;
      end
    end
    exp_bus_q.push_back({op == 8'h57, a, d});
    if (op == 8'h57) begin
      exp_q.push_back(8'h4B);
      if (RSP_X == 1) exp_q.push_back(8'h4B);
    end else begin
      x = 8'h00;
      for (int i = 0; i < 4; i++) begin
        exp_q.push_back(d[8*i +: 8]);
        x = x ^ d[8*i +: 8];
      end
      if (RSP_X == 1) exp_q.push_back(x);
    end
  endtask

  task automatic finish_scn(input string name);
    int n;
    n = 0;
    while (!(busy_o == 1'b0 && exp_q.size() == 0) && n < 6000) begin
      @(negedge clk);
      n++;
    end
    repeat (20) @(negedge clk);
    chk({name, "_busy"}, {63'd0, busy_o}, 64'd0);
    chk({name, "_tx_left"}, exp_q.size(), 64'd0);
    chk({name, "_bus_left"}, exp_bus_q.size(), 64'd0);
    chk({name, "_err_cnt"}, err_seen, exp_err);
    chk({name, "_tx_idle"}, {63'd0, tx_pin}, 64'd1);
  endtask

  initial begin : watchdog
    #(80000 * 10);
    $display("FAIL watchdog: got no end of test expected finish within 80000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    rst = 1'b1;
    rx_pin = 1'b1;
    rd_data = 32'h0;
    repeat (5) @(negedge clk);
    chk("rst_tx_pin", {63'd0, tx_pin}, 64'd1);
    chk("rst_req_we", {62'd0, mem_req_o, mem_we_o}, 64'd0);
    chk("rst_busy_err", {62'd0, busy_o, err_o}, 64'd0);
    chk("rst_addr", {32'd0, mem_addr_o}, 64'd0);
    chk("rst_data", {32'd0, mem_data_o}, 64'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 1: write
    build(8'h57, 32'h0000_1000, 32'hDEAD_BEEF);
    model_frame();
    chk("model_w_len", exp_q.size(), 1 + RSP_X);
    chk("model_w_rsp", {56'd0, exp_q[0]}, 64'h4B);
    chk("model_w_bus", {exp_bus_q[0][63:32], exp_bus_q[0][31:0]}, 64'h0000_1000_DEAD_BEEF);
    send_frame();
    finish_scn("write");
    chk("write_addr_hold", {32'd0, mem_addr_o}, 64'h1000);
    chk("write_data_hold", {32'd0, mem_data_o}, 64'hDEAD_BEEF);

    // 2: read, response bytes must be back-to-back (10 bits of 16 clocks)
    rd_data = 32'h1234_5678;
    build(8'h52, 32'h0000_0004, 32'h0);
    model_frame();
    chk("model_r_b0", {56'd0, exp_q[0]}, 64'h78);
    chk("model_r_b3", {56'd0, exp_q[3]}, 64'h12);
    send_frame();
    tx_starts_q.delete();
    finish_scn("read");
    chk("read_addr_hold", {32'd0, mem_addr_o}, 64'h4);
    chk("read_data_unchanged", {32'd0, mem_data_o}, 64'hDEAD_BEEF);
    chk("read_tx_count", tx_starts_q.size(), 4 + RSP_X);
    if (tx_starts_q.size() == 4 + RSP_X)
      for (int i = 1; i < tx_starts_q.size(); i++)
        chk("read_tx_gap", tx_starts_q[i] - tx_starts_q[i-1], 10 * BIT);

    // 3: bad opcode
    frame_q.delete();
    frame_q.push_back(8'h00);
    model_frame();
    chk("model_bad_rsp", {56'd0, exp_q[0]}, 64'h45);
    send_frame();
    finish_scn("badop");

    // 4: timeout mid-frame, then a full write recovers
    send_byte(8'h57, 1'b1);
    send_byte(8'h00, 1'b1);
    repeat (20) @(negedge clk);
    chk("timeout_busy_before", {63'd0, busy_o}, 64'd1);
    exp_err++;
    finish_scn("timeout");
    build(8'h57, 32'h0000_1000, 32'hDEAD_BEEF);
    model_frame();
    send_frame();
    finish_scn("after_timeout");

    // 5: framing error drops the frame; a short glitch yields no byte
    send_byte(8'h52, 1'b1);
    send_byte(8'h04, 1'b0);
    exp_err++;
    finish_scn("framing");
    rx_pin = 1'b0;
    repeat (3) @(negedge clk);
    rx_pin = 1'b1;
    repeat (100) @(negedge clk);
    finish_scn("glitch");

`ifdef UART_BRIDGE_CSUM_EN
    // 6: checksum mismatch
    build(8'h52, 32'h0000_0004, 32'h0);
    frame_q[5] = 8'h00;
    model_frame();
    send_frame();
    finish_scn("bad_csum");
`endif

    // Reset in the middle of a response aborts the transmit at once
    rd_data = 32'hA5C3_0F1E;
    build(8'h52, 32'h0000_0020, 32'h0);
    model_frame();
    send_frame();
    n = 0;
    while (tx_pin !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_resp_started", {63'd0, tx_pin}, 64'd0);
    repeat (40) @(negedge clk);
    rst = 1'b1;
    rst_epoch++;
    exp_q.delete();
    #1;
    chk("rst_mid_tx_pin", {63'd0, tx_pin}, 64'd1);
    chk("rst_mid_busy", {63'd0, busy_o}, 64'd0);
    repeat (200) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    build(8'h57, 32'hCAFE_0008, 32'h0102_0304);
    model_frame();
    send_frame();
    finish_scn("after_reset");
    chk("after_reset_addr", {32'd0, mem_addr_o}, 64'hCAFE_0008);
    chk("after_reset_data", {32'd0, mem_data_o}, 64'h0102_0304);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
